// File: rtl/zap_wb_slave_ram.sv
// zap_wb_slave_ram: Wishbone B3 classic slave over a word-wide RAM.
// Define ZAP_WB_SLAVE_ERR_EN to answer out-of-range requests with o_wb_err.
module zap_wb_slave_ram #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic [31:0] i_wb_adr,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);
    localparam int AW = $clog2(DEPTH);
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD =
        NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;
    logic          oor_q;

    logic [31:0]   mem [DEPTH];

    logic          req;
    logic [31:0]   off;
    logic          oor_in;
    logic          unused_bits;

    assign req = i_wb_cyc & i_wb_stb;
    assign off = i_wb_adr - BASE_ADDR;
    // Wrapped offset: anything below BASE_ADDR lands above the window too
`ifdef ZAP_WB_SLAVE_ERR_EN
    assign oor_in = |off[31:AW+2];
`else
    assign oor_in = 1'b0;
`endif
    assign unused_bits = ^off;

    logic          take;
    logic [AW-1:0] c_idx;
    logic          c_we;
    logic [3:0]    c_sel;
    logic [31:0]   c_dat;
    logic          c_oor;
    logic          wr;

    // Zero wait states go IDLE->ACK directly, so bypass the latches
    always_comb begin
        take  = 1'b0;
        c_idx = idx_q;
        c_we  = we_q;
        c_sel = sel_q;
        c_dat = dat_q;
        c_oor = oor_q;
        case (state)
            IDLE: begin
                take  = req & NO_WAIT;
                c_idx = off[AW+1:2];
                c_we  = i_wb_we;
                c_sel = i_wb_sel;
                c_dat = i_wb_dat;
                c_oor = oor_in;
            end
            WAIT: take = i_wb_cyc & (cnt == 4'd0);
            default: take = 1'b0;
        endcase
    end

    assign wr = take & c_we & ~c_oor & ~i_reset;

    always_ff @(posedge i_clk) begin
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (c_sel[b]) begin
                    mem[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            dat_q    <= 32'd0;
            oor_q    <= 1'b0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'd0;
        end else begin
            o_wb_ack <= take & ~c_oor;
            o_wb_err <= take & c_oor;
            o_wb_dat <= (take & ~c_oor) ? mem[c_idx] : 32'd0;
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q <= c_idx;
                        we_q  <= c_we;
                        sel_q <= c_sel;
                        dat_q <= c_dat;
                        oor_q <= c_oor;
                        if (NO_WAIT) begin
                            state <= ACK;
                        end else begin
                            cnt   <= WS_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!i_wb_cyc) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
